// File: rtl/mem_port_arbiter_if.sv
// Request, response and slow-RAM device signals shared by the two-port memory arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/device side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  r0_valid;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic                  r0_ready;
  logic                  r0_done;
  logic                  r0_err;
  logic [DATA_WIDTH-1:0] r0_rdata;

  logic                  r1_valid;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_ready;
  logic                  r1_done;
  logic                  r1_err;
  logic [DATA_WIDTH-1:0] r1_rdata;

  logic                  m_read_addr_valid;
  logic [ADDR_WIDTH-1:0] m_read_addr;
  logic                  m_write_addr_valid;
  logic [ADDR_WIDTH-1:0] m_write_addr;
  logic [DATA_WIDTH-1:0] m_write_data;
  logic                  m_addr_ready;
  logic                  m_done;
  logic [DATA_WIDTH-1:0] m_read_data;

  modport slave (
    input  r0_valid, r0_addr,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    input  m_addr_ready, m_done, m_read_data,
    output r0_ready, r0_done, r0_err, r0_rdata,
    output r1_ready, r1_done, r1_err, r1_rdata,
    output m_read_addr_valid, m_read_addr,
    output m_write_addr_valid, m_write_addr, m_write_data
  );

  modport master (
    output r0_valid, r0_addr,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    output m_addr_ready, m_done, m_read_data,
    input  r0_ready, r0_done, r0_err, r0_rdata,
    input  r1_ready, r1_done, r1_err, r1_rdata,
    input  m_read_addr_valid, m_read_addr,
    input  m_write_addr_valid, m_write_addr, m_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares the slow RAM command port between a fetch port (0) and a data port (1).
// It runs one transaction at a time and adds an optional completion timeout.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               TO_EN    = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                state_r;
  state_e                state_s;
  logic                  take_s;
  logic                  gid_s;
  logic                  accept_s;
  logic                  fin_ok_s;
  logic                  fin_to_s;
  logic                  r0_ready_s;
  logic                  r1_ready_s;

  logic                  last_grant_r;
  logic                  gid_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  rd_vld_r;
  logic                  wr_vld_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  r0_done_r;
  logic                  r1_done_r;
  logic                  r0_err_r;
  logic                  r1_err_r;
  logic [DATA_WIDTH-1:0] r0_rdata_r;
  logic [DATA_WIDTH-1:0] r1_rdata_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, grant and completion decode
  always_comb begin
    state_s    = state_r;
    take_s     = 1'b0;
    gid_s      = 1'b0;
    accept_s   = 1'b0;
    fin_ok_s   = 1'b0;
    fin_to_s   = 1'b0;
    r0_ready_s = 1'b0;
    r1_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.r0_valid || bus.r1_valid) begin
          take_s     = 1'b1;
          // On a tie, the port that was not granted last time wins.
          gid_s      = bus.r1_valid && (!bus.r0_valid || !last_grant_r);
          r0_ready_s = !gid_s;
          r1_ready_s = gid_s;
          state_s    = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.m_addr_ready) begin
          accept_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (bus.m_done) begin
          fin_ok_s = 1'b1;
          state_s  = ST_IDLE;
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          fin_to_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Latched command and device-side valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      gid_r        <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      rd_vld_r     <= 1'b0;
      wr_vld_r     <= 1'b0;
    end else if (take_s) begin
      last_grant_r <= gid_s;
      gid_r        <= gid_s;
      addr_r       <= gid_s ? bus.r1_addr : bus.r0_addr;
      wdata_r      <= gid_s ? bus.r1_wdata : '0;
      rd_vld_r     <= !(gid_s && bus.r1_we);
      wr_vld_r     <= gid_s && bus.r1_we;
    end else if (accept_s) begin
      rd_vld_r <= 1'b0;
      wr_vld_r <= 1'b0;
    end else begin
      rd_vld_r <= rd_vld_r;
      wr_vld_r <= wr_vld_r;
    end
  end

  // Saturating WAIT-cycle counter, cleared when the device accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= '0;
    end else if ((state_r == ST_WAIT) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Completion pulses and per-port read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_done_r  <= 1'b0;
      r1_done_r  <= 1'b0;
      r0_err_r   <= 1'b0;
      r1_err_r   <= 1'b0;
      r0_rdata_r <= '0;
      r1_rdata_r <= '0;
    end else begin
      r0_done_r <= (fin_ok_s || fin_to_s) && !gid_r;
      r1_done_r <= (fin_ok_s || fin_to_s) && gid_r;
      r0_err_r  <= fin_to_s && !gid_r;
      r1_err_r  <= fin_to_s && gid_r;
      if ((fin_ok_s || fin_to_s) && !gid_r) begin
        r0_rdata_r <= fin_ok_s ? bus.m_read_data : '0;
      end else begin
        r0_rdata_r <= r0_rdata_r;
      end
      if ((fin_ok_s || fin_to_s) && gid_r) begin
        r1_rdata_r <= fin_ok_s ? bus.m_read_data : '0;
      end else begin
        r1_rdata_r <= r1_rdata_r;
      end
    end
  end

  assign bus.r0_ready           = r0_ready_s;
  assign bus.r1_ready           = r1_ready_s;
  assign bus.r0_done            = r0_done_r;
  assign bus.r1_done            = r1_done_r;
  assign bus.r0_err             = r0_err_r;
  assign bus.r1_err             = r1_err_r;
  assign bus.r0_rdata           = r0_rdata_r;
  assign bus.r1_rdata           = r1_rdata_r;
  assign bus.m_read_addr_valid  = rd_vld_r;
  assign bus.m_write_addr_valid = wr_vld_r;
  assign bus.m_read_addr        = addr_r;
  assign bus.m_write_addr       = addr_r;
  assign bus.m_write_data       = wdata_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked each cycle against a transaction-level model; a second instance covers an 8-cycle timeout.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus8 ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, a, e);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one held request, accepted flag, wait count, expected completions.
  bit          mdl_busy;
  bit          mdl_acc;
  int          mdl_wait;
  bit          mdl_last;
  bit          mdl_port;
  bit          mdl_we;
  logic [31:0] mdl_addr;
  logic [31:0] mdl_wdata;
  bit          exp_done [2];
  bit          exp_err  [2];
  logic [31:0] exp_rdata[2];

  initial begin
    bit v0, v1, pick, ex_rd, ex_wr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_busy = 1'b0; mdl_acc = 1'b0; mdl_wait = 0; mdl_last = 1'b1;
        for (int p = 0; p < 2; p++) begin
          exp_done[p] = 1'b0; exp_err[p] = 1'b0; exp_rdata[p] = 32'h0;
        end
        chk1("rst_rd_valid", bus.m_read_addr_valid, 1'b0);
        chk1("rst_wr_valid", bus.m_write_addr_valid, 1'b0);
        chk1("rst_r0_done", bus.r0_done, 1'b0);
        chk1("rst_r1_done", bus.r1_done, 1'b0);
        chk1("rst_r0_err", bus.r0_err, 1'b0);
        chk1("rst_r1_err", bus.r1_err, 1'b0);
        chk32("rst_r0_rdata", bus.r0_rdata, 32'h0);
        chk32("rst_r1_rdata", bus.r1_rdata, 32'h0);
      end else begin
        v0    = bus.r0_valid;
        v1    = bus.r1_valid;
        pick  = (v0 && v1) ? !mdl_last : v1;
        ex_rd = mdl_busy && !mdl_acc && !mdl_we;
        ex_wr = mdl_busy && !mdl_acc && mdl_we;
        chk1("m_r0_ready", bus.r0_ready, !mdl_busy && v0 && !pick);
        chk1("m_r1_ready", bus.r1_ready, !mdl_busy && v1 && pick);
        chk1("m_rd_valid", bus.m_read_addr_valid, ex_rd);
        chk1("m_wr_valid", bus.m_write_addr_valid, ex_wr);
        if (ex_rd) chk32("m_rd_addr", bus.m_read_addr, mdl_addr);
        if (ex_wr) begin
          chk32("m_wr_addr", bus.m_write_addr, mdl_addr);
          chk32("m_wr_data", bus.m_write_data, mdl_wdata);
        end
        chk1("m_r0_done", bus.r0_done, exp_done[0]);
        chk1("m_r1_done", bus.r1_done, exp_done[1]);
        chk1("m_r0_err", bus.r0_err, exp_err[0]);
        chk1("m_r1_err", bus.r1_err, exp_err[1]);
        chk32("m_r0_rdata", bus.r0_rdata, exp_rdata[0]);
        chk32("m_r1_rdata", bus.r1_rdata, exp_rdata[1]);
        exp_done[0] = 1'b0; exp_done[1] = 1'b0;
        exp_err[0]  = 1'b0; exp_err[1]  = 1'b0;
        if (mdl_busy && mdl_acc) begin
          if (bus.m_done) begin
            exp_done[mdl_port]  = 1'b1;
            exp_rdata[mdl_port] = bus.m_read_data;
            mdl_busy = 1'b0;
          end else begin
            mdl_wait++;
            if (mdl_wait == TO) begin
              exp_done[mdl_port]  = 1'b1;
              exp_err[mdl_port]   = 1'b1;
              exp_rdata[mdl_port] = 32'h0;
              mdl_busy = 1'b0;
            end
          end
        end else if (mdl_busy) begin
          if (bus.m_addr_ready) begin
            mdl_acc  = 1'b1;
            mdl_wait = 0;
          end
        end else if (v0 || v1) begin
          mdl_busy  = 1'b1;
          mdl_acc   = 1'b0;
          mdl_port  = pick;
          mdl_we    = pick && bus.r1_we;
          mdl_addr  = pick ? bus.r1_addr : bus.r0_addr;
          mdl_wdata = bus.r1_wdata;
          mdl_last  = pick;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs0, hs1, acc, dev_pend;
    int dev_cnt;
    int gq[$];
    int dq[$];
    rst_n = 1'b0;
    bus.r0_valid = 1'b0; bus.r0_addr = '0; bus.r1_valid = 1'b0; bus.r1_we = 1'b0;
    bus.r1_addr = '0; bus.r1_wdata = '0; bus.m_addr_ready = 1'b0; bus.m_done = 1'b0; bus.m_read_data = '0;
    bus8.r0_valid = 1'b0; bus8.r0_addr = '0; bus8.r1_valid = 1'b0; bus8.r1_we = 1'b0;
    bus8.r1_addr = '0; bus8.r1_wdata = '0; bus8.m_addr_ready = 1'b0; bus8.m_done = 1'b0; bus8.m_read_data = '0;
    repeat (3) @(negedge clk);
    nxt(); rst_n = 1'b1;

    // Port 0 read of 0x10, completion 11 cycles after accept
    bus.r0_valid = 1'b1; bus.r0_addr = 32'h10; bus.m_addr_ready = 1'b1;
    @(negedge clk);
    chk1("t1_r0_ready", bus.r0_ready, 1'b1);
    chk1("t1_r1_ready", bus.r1_ready, 1'b0);
    nxt(); bus.r0_valid = 1'b0;
    @(negedge clk);
    chk1("t1_rd_valid", bus.m_read_addr_valid, 1'b1);
    chk32("t1_rd_addr", bus.m_read_addr, 32'h10);
    chk1("t1_wr_valid", bus.m_write_addr_valid, 1'b0);
    for (int i = 2; i < 12; i++) begin
      nxt(); @(negedge clk);
      chk1("t1_early_done", bus.r0_done, 1'b0);
    end
    nxt(); bus.m_done = 1'b1; bus.m_read_data = 32'hDEADBEEF;
    @(negedge clk);
    nxt(); bus.m_done = 1'b0; bus.m_read_data = 32'h55;
    @(negedge clk);
    chk1("t1_r0_done", bus.r0_done, 1'b1);
    chk1("t1_r0_err", bus.r0_err, 1'b0);
    chk32("t1_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
    nxt(); @(negedge clk);
    chk1("t1_done_pulse", bus.r0_done, 1'b0);
    chk32("t1_rdata_hold", bus.r0_rdata, 32'hDEADBEEF);

    // Port 1 write of 0xCAFEF00D to 0x20
    nxt(); bus.r1_valid = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 32'h20; bus.r1_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk1("t2_r1_ready", bus.r1_ready, 1'b1);
    nxt(); bus.r1_valid = 1'b0;
    @(negedge clk);
    chk1("t2_wr_valid", bus.m_write_addr_valid, 1'b1);
    chk1("t2_rd_valid", bus.m_read_addr_valid, 1'b0);
    chk32("t2_wr_addr", bus.m_write_addr, 32'h20);
    chk32("t2_wr_data", bus.m_write_data, 32'hCAFEF00D);
    nxt(); bus.m_done = 1'b1;
    @(negedge clk);
    nxt(); bus.m_done = 1'b0;
    @(negedge clk);
    chk1("t2_r1_done", bus.r1_done, 1'b1);
    chk1("t2_r1_err", bus.r1_err, 1'b0);
    chk1("t2_r0_quiet", bus.r0_done, 1'b0);

    // Both ports valid continuously: grants and completions alternate 0,1,0,1
    nxt();
    bus.r0_valid = 1'b1; bus.r0_addr = 32'h100; bus.r1_valid = 1'b1; bus.r1_we = 1'b0;
    bus.r1_addr = 32'h200; bus.m_addr_ready = 1'b1; bus.m_done = 1'b1;
    for (int i = 0; i < 40 && dq.size() < 4; i++) begin
      @(negedge clk);
      if (bus.r0_ready) gq.push_back(0);
      if (bus.r1_ready) gq.push_back(1);
      if (bus.r0_done) dq.push_back(0);
      if (bus.r1_done) dq.push_back(1);
      nxt();
      if (gq.size() >= 4) begin
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
      end
    end
    bus.m_done = 1'b0;
    chki("t3_done_count", dq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chki("t3_grant_order", (i < gq.size()) ? gq[i] : -1, i % 2);
      chki("t3_done_order", (i < dq.size()) ? dq[i] : -1, i % 2);
    end
    @(negedge clk);

    // Device not ready for 5 cycles: command held stable, accepted on first ready edge
    nxt(); bus.r0_valid = 1'b1; bus.r0_addr = 32'h44; bus.m_addr_ready = 1'b0;
    @(negedge clk);
    chk1("t4_r0_ready", bus.r0_ready, 1'b1);
    nxt(); bus.r0_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk1("t4_rd_hold", bus.m_read_addr_valid, 1'b1);
      chk32("t4_addr_hold", bus.m_read_addr, 32'h44);
      chk1("t4_no_done", bus.r0_done, 1'b0);
      nxt();
    end
    bus.m_addr_ready = 1'b1;
    @(negedge clk);
    chk1("t4_rd_at_accept", bus.m_read_addr_valid, 1'b1);
    nxt(); bus.m_addr_ready = 1'b0; bus.m_done = 1'b1; bus.m_read_data = 32'hA5A50044;
    @(negedge clk);
    chk1("t4_rd_dropped", bus.m_read_addr_valid, 1'b0);
    nxt(); bus.m_done = 1'b0;
    @(negedge clk);
    chk1("t4_r0_done", bus.r0_done, 1'b1);
    chk32("t4_r0_rdata", bus.r0_rdata, 32'hA5A50044);

    // Reset during WAIT, then stale completions
    nxt(); bus.r1_valid = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 32'h80; bus.m_addr_ready = 1'b1;
    @(negedge clk);
    chk1("t5_r1_ready", bus.r1_ready, 1'b1);
    nxt(); bus.r1_valid = 1'b0;
    @(negedge clk);
    nxt(); @(negedge clk);
    chk1("t5_in_wait", bus.m_read_addr_valid, 1'b0);
    nxt(); rst_n = 1'b0;
    @(negedge clk);
    chk32("t5_r0_rdata", bus.r0_rdata, 32'h0);
    chk32("t5_r1_rdata", bus.r1_rdata, 32'h0);
    chk1("t5_r1_done", bus.r1_done, 1'b0);
    nxt(); rst_n = 1'b1; bus.m_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("t5_stale_r0", bus.r0_done, 1'b0);
      chk1("t5_stale_r1", bus.r1_done, 1'b0);
      nxt();
      if (i == 1) bus.m_done = 1'b0;
    end
    @(negedge clk);

    // Random traffic with a device that is sometimes busy, sometimes very late, sometimes spurious
    dev_pend = 1'b0; dev_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      hs0 = bus.r0_valid && bus.r0_ready;
      hs1 = bus.r1_valid && bus.r1_ready;
      acc = (bus.m_read_addr_valid || bus.m_write_addr_valid) && bus.m_addr_ready;
      nxt();
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      if (acc) begin
        dev_pend = 1'b1;
        dev_cnt  = ($urandom_range(0, 15) == 0) ? 70 : int'($urandom_range(0, 5));
      end
      if (dev_pend && dev_cnt == 0) begin
        bus.m_done = 1'b1;
        dev_pend   = 1'b0;
      end else begin
        if (dev_pend) dev_cnt--;
        bus.m_done = !dev_pend && ($urandom_range(0, 31) == 0);
      end
      bus.m_addr_ready = !dev_pend && ($urandom_range(0, 3) != 0);
      bus.m_read_data  = $urandom;
      if (!rst_n) begin
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
      end else begin
        if (!bus.r0_valid || hs0) begin
          bus.r0_valid = ($urandom_range(0, 2) != 0);
          bus.r0_addr  = $urandom;
        end
        if (!bus.r1_valid || hs1) begin
          bus.r1_valid = ($urandom_range(0, 2) != 0);
          bus.r1_we    = 1'($urandom_range(0, 1));
          bus.r1_addr  = $urandom;
          bus.r1_wdata = $urandom;
        end
      end
      @(negedge clk);
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;

    // TIMEOUT=8 instance: a good read, then a write whose completion never comes
    nxt(); bus8.r1_valid = 1'b1; bus8.r1_we = 1'b0; bus8.r1_addr = 32'h30; bus8.m_addr_ready = 1'b1;
    @(negedge clk);
    chk1("to_r1_ready_rd", bus8.r1_ready, 1'b1);
    nxt(); bus8.r1_valid = 1'b0;
    @(negedge clk);
    chk1("to_rd_valid", bus8.m_read_addr_valid, 1'b1);
    nxt(); bus8.m_done = 1'b1; bus8.m_read_data = 32'h12345678;
    @(negedge clk);
    nxt(); bus8.m_done = 1'b0;
    @(negedge clk);
    chk1("to_rd_done", bus8.r1_done, 1'b1);
    chk32("to_rd_rdata", bus8.r1_rdata, 32'h12345678);
    nxt(); bus8.r1_valid = 1'b1; bus8.r1_we = 1'b1; bus8.r1_addr = 32'h34; bus8.r1_wdata = 32'h1;
    @(negedge clk);
    chk1("to_r1_ready_wr", bus8.r1_ready, 1'b1);
    nxt(); bus8.r1_valid = 1'b0;
    @(negedge clk);
    chk1("to_wr_valid", bus8.m_write_addr_valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      nxt(); @(negedge clk);
      chk1("to_wait_no_done", bus8.r1_done, 1'b0);
    end
    nxt(); bus8.r0_valid = 1'b1; bus8.r0_addr = 32'h3C;
    @(negedge clk);
    chk1("to_err_done", bus8.r1_done, 1'b1);
    chk1("to_err_flag", bus8.r1_err, 1'b1);
    chk32("to_err_rdata", bus8.r1_rdata, 32'h0);
    chk1("to_idle_grant", bus8.r0_ready, 1'b1);
    nxt(); bus8.r0_valid = 1'b0;
    @(negedge clk);
    chk1("to_done_pulse", bus8.r1_done, 1'b0);
    chk1("to_err_pulse", bus8.r1_err, 1'b0);
    chk1("to_next_issue", bus8.m_read_addr_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
